// File: rtl/pm_pkg.sv
// Shared constants and helpers for the octant range-reduction front end.
package pm_pkg;
    localparam int DW        = 8;
    localparam int LATENCY   = DW + 2;
    localparam int FLAG_RNEG = 2;
    localparam int FLAG_INEG = 1;
    localparam int FLAG_SWAP = 0;
    localparam logic [DW-1:0] Q_SAT = 8'hFF;

    typedef logic [2:0] octant_t;

    // Magnitude of a two's-complement value as unsigned; -128 maps to 128.
    function automatic logic [DW-1:0] abs_mag(input logic [DW-1:0] x);
        return x[DW-1] ? (~x + 1'b1) : x;
    endfunction
endpackage

// File: rtl/pattern_match_if.sv
// Sample-in / ratio-out bus of the octant folding front end.
interface pattern_match_if;
    import pm_pkg::*;

    logic          val_i;
    logic [DW-1:0] real_i;
    logic [DW-1:0] imag_i;
    logic [DW-1:0] into_atan_poly;
    octant_t       case_flag;
    logic          val_o;

    modport master (
        output val_i, real_i, imag_i,
        input  into_atan_poly, case_flag, val_o
    );

    modport slave (
        input  val_i, real_i, imag_i,
        output into_atan_poly, case_flag, val_o
    );
endinterface

// File: rtl/pm_div_stage.sv
// One registered restoring-division step; STEP selects which quotient bit it resolves.
module pm_div_stage
    import pm_pkg::*;
#(
    parameter int STEP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] rem,
    input  logic [DW-1:0] divisor,
    input  logic [DW-1:0] quot,
    output logic [DW-1:0] rem_reg,
    output logic [DW-1:0] divisor_reg,
    output logic [DW-1:0] quot_reg
);
    logic [DW:0]   rem2;
    logic [DW:0]   rem_diff;
    logic          ge;
    logic [DW-1:0] rem_next;
    logic [DW-1:0] quot_next;

    // The remainder never exceeds the divisor, so the doubled value fits in DW+1 bits.
    always_comb begin
        rem2      = {rem, 1'b0};
        rem_diff  = rem2 - {1'b0, divisor};
        ge        = (rem2 >= {1'b0, divisor});
        rem_next  = ge ? rem_diff[DW-1:0] : rem2[DW-1:0];
        quot_next = quot;
        quot_next[DW-1-STEP] = ge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg     <= '0;
            divisor_reg <= '0;
            quot_reg    <= '0;
        end else begin
            rem_reg     <= rem_next;
            divisor_reg <= divisor;
            quot_reg    <= quot_next;
        end
    end
endmodule

// File: rtl/pattern_match.sv
// Folds a complex sample into the first octant and emits min/max as a Q0.8 ratio.
module pattern_match
    import pm_pkg::*;
(
    input logic             clk,
    input logic             rst,
    pattern_match_if.slave  bus
);
    logic [DW-1:0]      a_reg, b_reg;
    logic               sr_reg, si_reg;
    logic [DW-1:0]      mn_reg, mx_reg;
    logic               swap;
    logic [DW-1:0]      mn_next, mx_next;
    octant_t            flag_next;
    octant_t            flag_reg [0:DW];
    logic [LATENCY-1:0] val_pipe_reg;

    logic [DW-1:0] rem_w  [0:DW];
    logic [DW-1:0] div_w  [0:DW];
    logic [DW-1:0] quot_w [0:DW];
    logic [2*DW-1:0] unused_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            sr_reg <= 1'b0;
            si_reg <= 1'b0;
        end else begin
            a_reg  <= abs_mag(bus.real_i);
            b_reg  <= abs_mag(bus.imag_i);
            sr_reg <= bus.real_i[DW-1];
            si_reg <= bus.imag_i[DW-1];
        end
    end

    // A zero divisor only occurs for a 0+0j sample; dividing 0 by 1 yields q=0 and
    // the octant code is already 000, so no separate zero flag is needed downstream.
    // Equal magnitudes make every step subtract, which saturates q to all ones.
    always_comb begin
        swap      = (b_reg > a_reg);
        mx_next   = swap ? b_reg : a_reg;
        mn_next   = swap ? a_reg : b_reg;
        flag_next = '0;
        flag_next[FLAG_RNEG] = sr_reg;
        flag_next[FLAG_INEG] = si_reg;
        flag_next[FLAG_SWAP] = swap;
        if (mx_next == '0) begin
            mx_next = {{(DW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mn_reg <= '0;
            mx_reg <= '0;
            for (int i = 0; i <= DW; i++) begin
                flag_reg[i] <= '0;
            end
            val_pipe_reg <= '0;
        end else begin
            mn_reg      <= mn_next;
            mx_reg      <= mx_next;
            flag_reg[0] <= flag_next;
            for (int i = 1; i <= DW; i++) begin
                flag_reg[i] <= flag_reg[i-1];
            end
            val_pipe_reg <= {val_pipe_reg[LATENCY-2:0], bus.val_i};
        end
    end

    assign rem_w[0]  = mn_reg;
    assign div_w[0]  = mx_reg;
    assign quot_w[0] = '0;

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_div
            pm_div_stage #(.STEP(gi)) u_stage (
                .clk         (clk),
                .rst         (rst),
                .rem         (rem_w[gi]),
                .divisor     (div_w[gi]),
                .quot        (quot_w[gi]),
                .rem_reg     (rem_w[gi+1]),
                .divisor_reg (div_w[gi+1]),
                .quot_reg    (quot_w[gi+1])
            );
        end
    endgenerate

    assign unused_tail = {rem_w[DW], div_w[DW]};

    assign bus.into_atan_poly = quot_w[DW];
    assign bus.case_flag      = flag_reg[DW];
    assign bus.val_o          = val_pipe_reg[LATENCY-1];
endmodule

// File: tb/tb_pattern_match.sv
// Randomized and directed checks of pattern_match against a ratio/octant reference model.
module tb_pattern_match;
    localparam int LAT  = 10;
    localparam int HLEN = 4096;

    logic clk = 1'b0;
    logic rst;
    int   npe = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_out = 0;

    bit         hv [HLEN];
    bit         hr [HLEN];
    logic [7:0] hq [HLEN];
    logic [2:0] hf [HLEN];
    logic [7:0] hre [HLEN];
    logic [7:0] him [HLEN];

    pattern_match_if bus ();

    pattern_match dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) npe <= npe + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, npe);
        else
            n_pass++;
    endtask

    // Reference: ratio min/max of magnitudes, scaled by 256 and floored.
    function automatic void model(input logic [7:0] re, input logic [7:0] im,
                                  output logic [7:0] q, output logic [2:0] f);
        int a, b, mx, mn;
        a  = re[7] ? 256 - int'(re) : int'(re);
        b  = im[7] ? 256 - int'(im) : int'(im);
        mx = (b > a) ? b : a;
        mn = (b > a) ? a : b;
        if (mx == 0)       q = 8'h00;
        else if (mn == mx) q = 8'hFF;
        else               q = 8'((mn * 256) / mx);
        f = {re[7], im[7], (b > a)};
    endfunction

    task automatic step(input bit r, input bit v, input logic [7:0] re, input logic [7:0] im,
                        input bit use_tab, input logic [7:0] tq, input logic [2:0] tf);
        int n, idx;
        bit ev;
        logic [7:0] mq;
        logic [2:0] mf;
        @(negedge clk);
        n   = npe;
        idx = n - LAT;
        ev  = (idx >= 0) ? hv[idx] : 1'b0;
        check("val_o", 32'(bus.val_o), 32'(ev));
        if (ev) begin
            check("ratio", 32'(bus.into_atan_poly), 32'(hq[idx]));
            check("octant", 32'(bus.case_flag), 32'(hf[idx]));
            $display("out %0d: re=%02h im=%02h q=%02h flag=%03b", n_out, hre[idx], him[idx],
                     bus.into_atan_poly, bus.case_flag);
            n_out++;
        end
        if (n >= 1 && hr[n-1]) begin
            check("rst_ratio", 32'(bus.into_atan_poly), 32'h0);
            check("rst_octant", 32'(bus.case_flag), 32'h0);
        end
        rst        = r;
        bus.val_i  = v;
        bus.real_i = re;
        bus.imag_i = im;
        hr[n]  = r;
        hv[n]  = v && !r;
        hre[n] = re;
        him[n] = im;
        if (use_tab) begin
            hq[n] = tq;
            hf[n] = tf;
        end else begin
            model(re, im, mq, mf);
            hq[n] = mq;
            hf[n] = mf;
        end
        if (r) begin
            for (int k = n - (LAT - 1); k < n; k++)
                if (k >= 0) hv[k] = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'b000);
    endtask

    task automatic rnd(input bit v);
        step(1'b0, v, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'b0, 8'h00, 3'b000);
    endtask

    logic [7:0] t_re [7] = '{8'h40, 8'h20, 8'hC0, 8'h03, 8'h7F, 8'h80, 8'h00};
    logic [7:0] t_im [7] = '{8'h20, 8'h40, 8'h20, 8'h01, 8'h7F, 8'h80, 8'h00};
    logic [7:0] t_q  [7] = '{8'h80, 8'h80, 8'h80, 8'h55, 8'hFF, 8'hFF, 8'h00};
    logic [2:0] t_f  [7] = '{3'b000, 3'b001, 3'b100, 3'b000, 3'b000, 3'b110, 3'b000};

    initial begin
        rst        = 1'b1;
        bus.val_i  = 1'b0;
        bus.real_i = 8'h00;
        bus.imag_i = 8'h00;
        hr[0]      = 1'b1;

        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'b000);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'b000);
        idle(3);

        // Directed corner samples with hand-derived results.
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b1, t_re[i], t_im[i], 1'b1, t_q[i], t_f[i]);
        idle(12);

        // Valid toggling every other clock.
        for (int i = 0; i < 24; i++)
            rnd(i[0] == 1'b0);
        idle(12);

        // Back-to-back stream.
        for (int i = 0; i < 1024; i++)
            rnd(1'b1);
        idle(12);

        // Reset with five samples in flight, then a single sample after release.
        for (int i = 0; i < 5; i++)
            rnd(1'b1);
        step(1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h00, 3'b000);
        idle(3);
        rnd(1'b1);
        idle(14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
